// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared definitions for the CPU run-control / performance monitor:
// FSM state encoding and default counter sizing.
package pipeline_perf_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_CNT_W     = 32;
    localparam int DEFAULT_CYCLE_MAX = 64;

endpackage

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// Saturating up-counter: increments by one when en_i and inc_i are both high,
// sticks at all-ones, and is zeroed by reset or a synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic full;
    assign full = &cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
        end else if (en_i && inc_i && !full) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Run-control FSM plus cycle/stall/flush counters for the 5-stage CPU, with an
// atomic snapshot register so observers read a consistent counter set.
module pipeline_perf_monitor
    import pipeline_perf_monitor_pkg::*;
#(
    parameter int CNT_W     = DEFAULT_CNT_W,
    parameter int CYCLE_MAX = DEFAULT_CYCLE_MAX
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             hazard_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             snap_req_i,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic [31:0]      snap_pc_o,
    output logic             running_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    localparam logic [63:0] LIMIT      = 64'(CYCLE_MAX);
    localparam logic        ZERO_LIMIT = (CYCLE_MAX == 0);

    state_t           state;
    logic             in_run;
    logic             cycle_full;
    logic             limit_hit;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign in_run     = (state == S_RUN);
    assign state_o    = state;
    assign cycle_full = &cycle_cnt;
    // A saturated cycle counter can never reach a limit beyond its range, so
    // the FSM deliberately stays in RUN in that case.
    assign limit_hit  = ZERO_LIMIT ||
                        (!cycle_full && ((64'(cycle_cnt) + 64'd1) == LIMIT));

    // With a zero limit the first RUN edge already ends the run, so the
    // cycle counter is never advanced.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (in_run && !ZERO_LIMIT),
        .inc_i (1'b1),
        .cnt_o (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (in_run),
        .inc_i (hazard_i),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .en_i  (in_run),
        .inc_i (flush_i),
        .cnt_o (flush_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state     <= S_IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state     <= S_RUN;
                        running_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (limit_hit) begin
                        state     <= S_DONE;
                        running_o <= 1'b0;
                        done_o    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state     <= S_IDLE;
                    running_o <= 1'b0;
                    done_o    <= 1'b0;
                end
            endcase
        end
    end

    // snap_req_i has no ready: every request is taken, and snap_valid_o pulses
    // the following cycle with the counters as they stood before the request edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_valid_o <= 1'b0;
            snap_cycle_o <= '0;
            snap_stall_o <= '0;
            snap_flush_o <= '0;
            snap_pc_o    <= '0;
        end else begin
            snap_valid_o <= snap_req_i;
            if (snap_req_i) begin
                snap_cycle_o <= cycle_cnt;
                snap_stall_o <= stall_cnt;
                snap_flush_o <= flush_cnt;
                snap_pc_o    <= pc_i;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: three configurations share one stimulus
// stream and are each compared against an arithmetic reference model.
module tb_pipeline_perf_monitor;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst, start, clear, hazard, flush, snap_req;
    logic [31:0] pc;

    logic        o0_v, o0_run, o0_done;
    logic [31:0] o0_cyc, o0_stl, o0_fls, o0_pc;
    logic [1:0]  o0_st;
    logic        o1_v, o1_run, o1_done;
    logic [3:0]  o1_cyc, o1_stl, o1_fls;
    logic [31:0] o1_pc;
    logic [1:0]  o1_st;
    logic        o2_v, o2_run, o2_done;
    logic [31:0] o2_cyc, o2_stl, o2_fls, o2_pc;
    logic [1:0]  o2_st;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    pipeline_perf_monitor #(.CNT_W(32), .CYCLE_MAX(64)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .hazard_i(hazard), .flush_i(flush), .pc_i(pc), .snap_req_i(snap_req),
        .snap_valid_o(o0_v), .snap_cycle_o(o0_cyc), .snap_stall_o(o0_stl),
        .snap_flush_o(o0_fls), .snap_pc_o(o0_pc), .running_o(o0_run),
        .done_o(o0_done), .state_o(o0_st));

    pipeline_perf_monitor #(.CNT_W(4), .CYCLE_MAX(40)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .hazard_i(hazard), .flush_i(flush), .pc_i(pc), .snap_req_i(snap_req),
        .snap_valid_o(o1_v), .snap_cycle_o(o1_cyc), .snap_stall_o(o1_stl),
        .snap_flush_o(o1_fls), .snap_pc_o(o1_pc), .running_o(o1_run),
        .done_o(o1_done), .state_o(o1_st));

    pipeline_perf_monitor #(.CNT_W(32), .CYCLE_MAX(0)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .hazard_i(hazard), .flush_i(flush), .pc_i(pc), .snap_req_i(snap_req),
        .snap_valid_o(o2_v), .snap_cycle_o(o2_cyc), .snap_stall_o(o2_stl),
        .snap_flush_o(o2_fls), .snap_pc_o(o2_pc), .running_o(o2_run),
        .done_o(o2_done), .state_o(o2_st));

    // Reference model: phase 0=idle, 1=run, 2=done; counters as plain integers.
    typedef struct {
        int     phase;
        longint cyc, stl, fls;
        bit     v;
        longint s_cyc, s_stl, s_fls, s_pc;
    } mdl_t;

    mdl_t m[NI];
    int   wid[NI] = '{32, 4, 32};
    int   lim[NI] = '{64, 40, 0};

    function automatic mdl_t step(input mdl_t s, input int w, input int l,
                                  input bit r, input bit st, input bit cl,
                                  input bit hz, input bit fl, input bit sr,
                                  input logic [31:0] p);
        mdl_t   n = s;
        longint top = (longint'(1) << w) - 1;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.v = sr;
        if (sr) begin
            n.s_cyc = s.cyc;
            n.s_stl = s.stl;
            n.s_fls = s.fls;
            n.s_pc  = longint'(p);
        end
        if (cl) begin
            n.phase = 0; n.cyc = 0; n.stl = 0; n.fls = 0;
        end else if (s.phase == 0) begin
            if (st) n.phase = 1;
        end else if (s.phase == 1) begin
            if (hz && n.stl < top) n.stl++;
            if (fl && n.fls < top) n.fls++;
            if (l == 0) begin
                n.phase = 2;
            end else begin
                if (n.cyc < top) n.cyc++;
                if (n.cyc == longint'(l)) n.phase = 2;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++)
            m[i] = step(m[i], wid[i], lim[i], rst, start, clear, hazard, flush, snap_req, pc);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic mon(input int i, input logic run, input logic done, input logic v,
                       input logic [63:0] c, input logic [63:0] s, input logic [63:0] f,
                       input logic [63:0] p, input logic [1:0] st);
        chk($sformatf("u%0d.state", i), 64'(st), 64'(m[i].phase));
        chk($sformatf("u%0d.running", i), 64'(run), 64'(m[i].phase == 1));
        chk($sformatf("u%0d.done", i), 64'(done), 64'(m[i].phase == 2));
        chk($sformatf("u%0d.snap_valid", i), 64'(v), 64'(m[i].v));
        chk($sformatf("u%0d.snap_cycle", i), c, m[i].s_cyc);
        chk($sformatf("u%0d.snap_stall", i), s, m[i].s_stl);
        chk($sformatf("u%0d.snap_flush", i), f, m[i].s_fls);
        chk($sformatf("u%0d.snap_pc", i), p, m[i].s_pc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, o0_run, o0_done, o0_v, 64'(o0_cyc), 64'(o0_stl), 64'(o0_fls), 64'(o0_pc), o0_st);
            mon(1, o1_run, o1_done, o1_v, 64'(o1_cyc), 64'(o1_stl), 64'(o1_fls), 64'(o1_pc), o1_st);
            mon(2, o2_run, o2_done, o2_v, 64'(o2_cyc), 64'(o2_stl), 64'(o2_fls), 64'(o2_pc), o2_st);
        end
    end

    task automatic drive(input bit r, input bit s, input bit c, input bit h,
                         input bit f, input bit q, input logic [31:0] p);
        rst = r; start = s; clear = c; hazard = h; flush = f; snap_req = q; pc = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, start, clear, hz, fl, sr;
        logic [31:0] pc;
        logic        e_run, e_done, e_v, chk_d;
        logic [31:0] e_cyc, e_stl, e_fls, e_pc;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n;
        drive(1, 0, 0, 0, 0, 0, 32'h0);

        // Directed vectors on u0 (CYCLE_MAX=64): hazard on RUN edges 3-5,
        // flush on 5 and 9, snapshots on RUN edges 10/11, clear with snapshot.
        tbl[0]  = '{1,0,0,0,0,0,32'h0,   0,0,0,1, 0,0,0,32'h0};
        tbl[1]  = '{1,0,0,0,0,0,32'h0,   0,0,0,1, 0,0,0,32'h0};
        tbl[2]  = '{0,1,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[3]  = '{0,1,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[4]  = '{0,0,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[5]  = '{0,0,0,1,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[6]  = '{0,0,0,1,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[7]  = '{0,0,0,1,1,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[8]  = '{0,0,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[9]  = '{0,0,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[10] = '{0,0,0,0,0,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[11] = '{0,0,0,0,1,0,32'h0,   1,0,0,0, 0,0,0,32'h0};
        tbl[12] = '{0,0,0,0,0,1,32'h100, 1,0,1,1, 9,3,2,32'h100};
        tbl[13] = '{0,0,0,0,0,1,32'h104, 1,0,1,1, 10,3,2,32'h104};
        tbl[14] = '{0,0,0,0,0,0,32'h0,   1,0,0,1, 10,3,2,32'h104};
        tbl[15] = '{0,0,1,0,0,1,32'h108, 0,0,1,1, 12,3,2,32'h108};
        tbl[16] = '{0,0,0,0,0,1,32'h10c, 0,0,1,1, 0,0,0,32'h10c};
        tbl[17] = '{0,1,0,1,0,0,32'h0,   1,0,0,1, 0,0,0,32'h10c};
        tbl[18] = '{0,0,0,1,0,1,32'h110, 1,0,1,1, 0,0,0,32'h110};
        tbl[19] = '{0,0,0,0,0,1,32'h114, 1,0,1,1, 1,1,0,32'h114};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].clear, tbl[i].hz, tbl[i].fl, tbl[i].sr, tbl[i].pc);
            tick();
            mon_en = 1'b1;
            chk($sformatf("vec%0d.running", i), 64'(o0_run), 64'(tbl[i].e_run));
            chk($sformatf("vec%0d.done", i), 64'(o0_done), 64'(tbl[i].e_done));
            chk($sformatf("vec%0d.snap_valid", i), 64'(o0_v), 64'(tbl[i].e_v));
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d.snap_cycle", i), 64'(o0_cyc), 64'(tbl[i].e_cyc));
                chk($sformatf("vec%0d.snap_stall", i), 64'(o0_stl), 64'(tbl[i].e_stl));
                chk($sformatf("vec%0d.snap_flush", i), 64'(o0_fls), 64'(tbl[i].e_fls));
                chk($sformatf("vec%0d.snap_pc", i), 64'(o0_pc), 64'(tbl[i].e_pc));
            end
        end

        // Hazard held in IDLE is ignored.
        drive(1, 0, 0, 1, 0, 0, 32'h0); tick(); tick();
        drive(0, 0, 0, 1, 0, 0, 32'h0); tick(); tick(); tick();
        drive(0, 0, 0, 1, 0, 1, 32'h200); tick();
        chk("idle.snap_stall", 64'(o0_stl), 64'd0);
        chk("idle.snap_cycle", 64'(o0_cyc), 64'd0);
        chk("idle.running", 64'(o0_run), 64'd0);

        // Full run to the limit; zero-limit instance finishes one edge after start.
        drive(0, 1, 0, 0, 0, 0, 32'h0); tick();
        chk("start.u0_running", 64'(o0_run), 64'd1);
        chk("start.u2_running", 64'(o2_run), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        n = 0;
        while (o0_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("run.edges_to_done", 64'(n), 64'd64);
        chk("run.u2_done", 64'(o2_done), 64'd1);
        drive(0, 0, 0, 0, 0, 1, 32'h300); tick();
        chk("done.snap_cycle", 64'(o0_cyc), 64'd64);
        chk("done.snap_stall", 64'(o0_stl), 64'd0);
        chk("done.snap_flush", 64'(o0_fls), 64'd0);
        chk("done.running", 64'(o0_run), 64'd0);
        chk("done.u2_snap_cycle", 64'(o2_cyc), 64'd0);

        // Events in DONE are ignored and done stays sticky.
        drive(0, 0, 0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        drive(0, 0, 0, 1, 1, 1, 32'h304); tick();
        chk("done_frozen.snap_stall", 64'(o0_stl), 64'd0);
        chk("done_frozen.snap_flush", 64'(o0_fls), 64'd0);
        chk("done_frozen.snap_cycle", 64'(o0_cyc), 64'd64);
        chk("done_frozen.done", 64'(o0_done), 64'd1);

        // 4-bit counters saturate at 15 and the run never reaches 40.
        drive(0, 0, 1, 0, 0, 0, 32'h0); tick();
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 31; i++) tick();
        drive(0, 0, 0, 1, 0, 1, 32'h400); tick();
        chk("sat.u1_snap_cycle", 64'(o1_cyc), 64'd15);
        chk("sat.u1_snap_stall", 64'(o1_stl), 64'd15);
        chk("sat.u1_running", 64'(o1_run), 64'd1);
        chk("sat.u1_done", 64'(o1_done), 64'd0);

        // Reset on RUN cycle 20 aborts, and a coincident request is dropped.
        drive(0, 0, 1, 0, 0, 0, 32'h0); tick();
        drive(0, 1, 0, 0, 0, 0, 32'h0); tick();
        drive(0, 0, 0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 19; i++) tick();
        drive(1, 0, 0, 1, 1, 1, 32'h500); tick();
        chk("abort.running", 64'(o0_run), 64'd0);
        chk("abort.done", 64'(o0_done), 64'd0);
        chk("abort.snap_valid", 64'(o0_v), 64'd0);
        chk("abort.snap_cycle", 64'(o0_cyc), 64'd0);
        chk("abort.snap_stall", 64'(o0_stl), 64'd0);
        chk("abort.snap_pc", 64'(o0_pc), 64'd0);
        chk("abort.state", 64'(o0_st), 64'd0);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(79) == 0,
                  $urandom_range(1) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
                  $urandom);
            tick();
        end

        drive(0, 0, 0, 0, 0, 0, 32'h0);
        tick();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
